// File: rtl/lat_meas_pkg.sv
// Shared definitions for the GTF raw-link latency measurement sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lat_meas_pkg;

  localparam int TS_W_DEF  = 16;
  localparam int ACC_W_DEF = 32;

  // Sequencer states, kept as plain constants so older tools can read them.
  typedef logic [2:0] state_t;
  localparam state_t IDLE   = 3'd0;
  localparam state_t SAMPLE = 3'd1;
  localparam state_t ACCUM  = 3'd2;
  localparam state_t SETTLE = 3'd3;
  localparam state_t DONE   = 3'd4;

  // Reset value of the running minimum, so that the first sample always wins.
  localparam logic [TS_W_DEF-1:0] MIN_INIT = '1;

endpackage

// File: rtl/lat_stats_accum.sv
// Running latency statistics: last, min, max, saturating sum and sample index.
// Latency: a sample presented with sample_valid is reflected on the outputs next cycle.
// Backpressure: none; one sample accepted every cycle sample_valid is high.
// Ports: clk/rst (sync, active-high), clear (pulse, zeroes stats), sample_valid/adj (input sample),
//        acc/idx/max/min/last/ovf (registered stats), idx_next (index after the current sample).
module lat_stats_accum
  import lat_meas_pkg::*;
#(
  parameter int TS_W  = TS_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             sample_valid,
  input  logic [TS_W-1:0]  adj,
  output logic [ACC_W-1:0] acc,
  output logic [ACC_W-1:0] idx,
  output logic [ACC_W-1:0] idx_next,
  output logic [TS_W-1:0]  max,
  output logic [TS_W-1:0]  min,
  output logic [TS_W-1:0]  last,
  output logic             ovf
);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] idx_q;
  logic [TS_W-1:0]  max_q;
  logic [TS_W-1:0]  min_q;
  logic [TS_W-1:0]  last_q;
  logic             ovf_q;
  logic [ACC_W:0]   acc_sum;

  // One extra bit catches the carry that signals saturation.
  assign acc_sum  = {1'b0, acc_q} + (ACC_W+1)'(adj);
  // Index sticks at all-ones rather than wrapping back to zero.
  assign idx_next = (&idx_q) ? idx_q : idx_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc_q  <= '0;
      idx_q  <= '0;
      max_q  <= '0;
      min_q  <= {TS_W{1'b1}};
      last_q <= '0;
      ovf_q  <= 1'b0;
    end else if (sample_valid) begin
      last_q <= adj;
      if (adj > max_q) max_q <= adj;
      if (adj < min_q) min_q <= adj;
      if (acc_sum[ACC_W]) begin
        acc_q <= '1;
        ovf_q <= 1'b1;
      end else begin
        acc_q <= acc_sum[ACC_W-1:0];
      end
      idx_q <= idx_next;
    end
  end

  assign acc  = acc_q;
  assign idx  = idx_q;
  assign max  = max_q;
  assign min  = min_q;
  assign last = last_q;
  assign ovf  = ovf_q;

endmodule

// File: rtl/lat_meas_sequencer.sv
// Drains the TX/RX timestamp FIFO one entry at a time and feeds offset-corrected deltas to the stats block.
// Latency: pending seen in IDLE at cycle N -> pop at N+1, stats updated at N+2; one sample per 4 cycles.
// Backpressure: pops only when fifo_pending != 0 and lat_enable is high; DONE holds off all pops until cleared.
// Ports: aclk/areset (sync, active-high); lat_enable/lat_clear/lat_pkt_cnt/lat_offset from control regs;
//        fifo_pending/fifo_tx_time/fifo_rx_time/fifo_pop to the timestamp FIFO;
//        delta_acc/idx/max/min/adj, busy, done, acc_ovf to the status regs.
module lat_meas_sequencer
  import lat_meas_pkg::*;
#(
  parameter int TS_W  = TS_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             lat_enable,
  input  logic             lat_clear,
  input  logic [15:0]      lat_pkt_cnt,
  input  logic [15:0]      lat_offset,
  input  logic [15:0]      fifo_pending,
  input  logic [TS_W-1:0]  fifo_tx_time,
  input  logic [TS_W-1:0]  fifo_rx_time,
  output logic             fifo_pop,
  output logic [ACC_W-1:0] delta_acc,
  output logic [ACC_W-1:0] delta_idx,
  output logic [TS_W-1:0]  delta_max,
  output logic [TS_W-1:0]  delta_min,
  output logic [TS_W-1:0]  delta_adj,
  output logic             busy,
  output logic             done,
  output logic             acc_ovf
);

  state_t           state;
  logic [TS_W-1:0]  raw;
  logic [TS_W-1:0]  offset_ts;
  logic [TS_W-1:0]  adj_calc;
  logic [TS_W-1:0]  adj_q;
  logic [ACC_W-1:0] idx_next;
  logic             sample_valid;
  logic             hit_cnt;

  // Modular subtraction absorbs a TX timestamp wrap without special casing.
  assign raw       = fifo_rx_time - fifo_tx_time;
  assign offset_ts = TS_W'(lat_offset);
  assign adj_calc  = (raw >= offset_ts) ? raw - offset_ts : '0;

  // Packet count is compared live so firmware may retarget a run in flight.
  assign hit_cnt = (lat_pkt_cnt != 16'd0) && (idx_next == ACC_W'(lat_pkt_cnt));

  always_ff @(posedge aclk) begin
    if (areset || lat_clear) begin
      state <= IDLE;
      adj_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (lat_enable && (fifo_pending != 16'd0)) state <= SAMPLE;
        end
        SAMPLE: begin
          adj_q <= adj_calc;
          state <= ACCUM;
        end
        ACCUM:   state <= hit_cnt ? DONE : SETTLE;
        // Gives the FIFO a cycle to present the new head and pending count.
        SETTLE:  state <= IDLE;
        DONE:    state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  // Pop is combinational so a clear landing in SAMPLE leaves the entry in place.
  assign fifo_pop     = (state == SAMPLE) && !lat_clear && !areset;
  assign sample_valid = (state == ACCUM) && !lat_clear;
  assign busy         = (state == SAMPLE) || (state == ACCUM) || (state == SETTLE);
  assign done         = (state == DONE);

  lat_stats_accum #(
    .TS_W  (TS_W),
    .ACC_W (ACC_W)
  ) u_stats (
    .clk          (aclk),
    .rst          (areset),
    .clear        (lat_clear),
    .sample_valid (sample_valid),
    .adj          (adj_q),
    .acc          (delta_acc),
    .idx          (delta_idx),
    .idx_next     (idx_next),
    .max          (delta_max),
    .min          (delta_min),
    .last         (delta_adj),
    .ovf          (acc_ovf)
  );

endmodule

// File: tb/tb_lat_meas_sequencer.sv
// Directed bench for lat_meas_sequencer with a small timestamp FIFO model.
// Latency: n/a.
// Backpressure: n/a.
module tb_lat_meas_sequencer;

  logic        aclk = 1'b0;
  logic        areset, lat_enable, lat_clear;
  logic [15:0] lat_pkt_cnt, lat_offset, fifo_pending, fifo_tx_time, fifo_rx_time;
  logic        fifo_pop, busy, done, acc_ovf;
  logic [31:0] delta_acc, delta_idx;
  logic [15:0] delta_max, delta_min, delta_adj;

  logic [15:0] q_tx[$];
  logic [15:0] q_rx[$];
  int          pop_cnt;
  bit          pop_due;
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 aclk = ~aclk;

  lat_meas_sequencer dut (
    .aclk(aclk), .areset(areset), .lat_enable(lat_enable), .lat_clear(lat_clear),
    .lat_pkt_cnt(lat_pkt_cnt), .lat_offset(lat_offset), .fifo_pending(fifo_pending),
    .fifo_tx_time(fifo_tx_time), .fifo_rx_time(fifo_rx_time), .fifo_pop(fifo_pop),
    .delta_acc(delta_acc), .delta_idx(delta_idx), .delta_max(delta_max),
    .delta_min(delta_min), .delta_adj(delta_adj), .busy(busy), .done(done),
    .acc_ovf(acc_ovf)
  );

  task automatic upd_head();
    fifo_pending = 16'(q_tx.size());
    if (q_tx.size() != 0) begin
      fifo_tx_time = q_tx[0];
      fifo_rx_time = q_rx[0];
    end else begin
      fifo_tx_time = 16'h0;
      fifo_rx_time = 16'h0;
    end
  endtask

  task automatic push(input logic [15:0] tx, input logic [15:0] rx);
    q_tx.push_back(tx);
    q_rx.push_back(rx);
    upd_head();
  endtask

  task automatic flush();
    q_tx.delete();
    q_rx.delete();
    upd_head();
  endtask

  // Pop is seen on the falling edge and applied just after the next rising edge,
  // so the DUT captures the old head on that edge.
  task automatic cycle();
    @(negedge aclk);
    pop_due = fifo_pop;
    if (fifo_pop) pop_cnt++;
    @(posedge aclk);
    #1;
    if (pop_due && q_tx.size() != 0) begin
      void'(q_tx.pop_front());
      void'(q_rx.pop_front());
    end
    upd_head();
  endtask

  task automatic do_clear();
    lat_clear = 1'b1;
    cycle();
    lat_clear = 1'b0;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    repeat (2) cycle();
    areset = 1'b0;
    n_checks++; if (fifo_pop !== 1'b0) $display("FAIL reset_pop: got %b want 0", fifo_pop); else n_pass++;
    n_checks++; if (delta_acc !== 32'h0) $display("FAIL reset_acc: got %h want 0", delta_acc); else n_pass++;
    n_checks++; if (delta_idx !== 32'h0) $display("FAIL reset_idx: got %h want 0", delta_idx); else n_pass++;
    n_checks++; if (delta_max !== 16'h0) $display("FAIL reset_max: got %h want 0", delta_max); else n_pass++;
    n_checks++; if (delta_min !== 16'hFFFF) $display("FAIL reset_min: got %h want ffff", delta_min); else n_pass++;
    n_checks++; if (delta_adj !== 16'h0) $display("FAIL reset_adj: got %h want 0", delta_adj); else n_pass++;
    n_checks++; if ({busy, done, acc_ovf} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {busy, done, acc_ovf}); else n_pass++;
  endtask

  task automatic test_empty();
    pop_cnt = 0;
    lat_enable = 1'b1;
    repeat (6) cycle();
    n_checks++; if (pop_cnt !== 0) $display("FAIL empty_pops: got %0d want 0", pop_cnt); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL empty_busy: got %b want 0", busy); else n_pass++;
    lat_enable = 1'b0;
  endtask

  task automatic test_single();
    pop_cnt = 0;
    lat_pkt_cnt = 16'd1;
    lat_offset = 16'h0010;
    push(16'h0100, 16'h0164);
    lat_enable = 1'b1;
    cycle();
    n_checks++; if ({fifo_pop, busy} !== 2'b11) $display("FAIL single_pop_timing: got %b want 11", {fifo_pop, busy}); else n_pass++;
    cycle();
    n_checks++; if (fifo_pop !== 1'b0) $display("FAIL single_pop_width: got %b want 0", fifo_pop); else n_pass++;
    cycle();
    n_checks++; if (delta_adj !== 16'h0054) $display("FAIL single_adj: got %h want 0054", delta_adj); else n_pass++;
    n_checks++; if (delta_acc !== 32'h54) $display("FAIL single_acc: got %h want 54", delta_acc); else n_pass++;
    n_checks++; if (delta_idx !== 32'd1) $display("FAIL single_idx: got %0d want 1", delta_idx); else n_pass++;
    n_checks++; if ({delta_max, delta_min} !== {16'h0054, 16'h0054}) $display("FAIL single_maxmin: got %h/%h want 0054/0054", delta_max, delta_min); else n_pass++;
    n_checks++; if ({done, busy} !== 2'b10) $display("FAIL single_done: got %b want 10", {done, busy}); else n_pass++;
    repeat (4) cycle();
    n_checks++; if (pop_cnt !== 1) $display("FAIL single_pops: got %0d want 1", pop_cnt); else n_pass++;
  endtask

  task automatic test_wrap();
    do_clear();
    lat_pkt_cnt = 16'd2;
    lat_offset = 16'h0000;
    push(16'hFFF0, 16'h0010);
    repeat (5) cycle();
    n_checks++; if (delta_adj !== 16'h0020) $display("FAIL wrap_adj: got %h want 0020", delta_adj); else n_pass++;
    n_checks++; if ({delta_idx, done} !== {32'd1, 1'b0}) $display("FAIL wrap_idx: got %0d/%b want 1/0", delta_idx, done); else n_pass++;
    lat_offset = 16'h0030;
    push(16'h1000, 16'h1020);
    repeat (5) cycle();
    n_checks++; if (delta_adj !== 16'h0000) $display("FAIL floor_adj: got %h want 0000", delta_adj); else n_pass++;
    n_checks++; if ({delta_min, delta_max} !== {16'h0000, 16'h0020}) $display("FAIL floor_minmax: got %h/%h want 0000/0020", delta_min, delta_max); else n_pass++;
    n_checks++; if ({delta_acc, done} !== {32'h20, 1'b1}) $display("FAIL floor_acc_done: got %h/%b want 20/1", delta_acc, done); else n_pass++;
  endtask

  task automatic test_stats();
    do_clear();
    pop_cnt = 0;
    lat_pkt_cnt = 16'd3;
    lat_offset = 16'd5;
    push(16'd100, 16'd115);
    push(16'd200, 16'd235);
    push(16'd300, 16'd325);
    push(16'd400, 16'd499);
    push(16'd500, 16'd599);
    repeat (20) cycle();
    n_checks++; if (delta_acc !== 32'd60) $display("FAIL stats_acc: got %0d want 60", delta_acc); else n_pass++;
    n_checks++; if ({delta_max, delta_min} !== {16'd30, 16'd10}) $display("FAIL stats_maxmin: got %0d/%0d want 30/10", delta_max, delta_min); else n_pass++;
    n_checks++; if ({delta_idx, done} !== {32'd3, 1'b1}) $display("FAIL stats_idx_done: got %0d/%b want 3/1", delta_idx, done); else n_pass++;
    n_checks++; if (delta_adj !== 16'd20) $display("FAIL stats_last: got %0d want 20", delta_adj); else n_pass++;
    n_checks++; if (pop_cnt !== 3) $display("FAIL stats_pops: got %0d want 3", pop_cnt); else n_pass++;
    n_checks++; if (fifo_pending !== 16'd2) $display("FAIL stats_pending: got %0d want 2", fifo_pending); else n_pass++;
    lat_enable = 1'b0;
    flush();
  endtask

  task automatic test_clear_in_sample();
    do_clear();
    pop_cnt = 0;
    lat_pkt_cnt = 16'd0;
    lat_offset = 16'd0;
    lat_enable = 1'b1;
    push(16'h0000, 16'h0040);
    repeat (5) cycle();
    n_checks++; if (delta_acc !== 32'h40) $display("FAIL clr_pre_acc: got %h want 40", delta_acc); else n_pass++;
    push(16'h0000, 16'h0040);
    cycle();
    lat_clear = 1'b1;
    #1;
    n_checks++; if ({fifo_pop, busy} !== 2'b01) $display("FAIL clr_sample_pop: got %b want 01", {fifo_pop, busy}); else n_pass++;
    cycle();
    lat_clear = 1'b0;
    lat_enable = 1'b0;
    n_checks++; if ({delta_acc, delta_idx} !== 64'h0) $display("FAIL clr_acc_idx: got %h/%h want 0/0", delta_acc, delta_idx); else n_pass++;
    n_checks++; if ({delta_max, delta_min, delta_adj} !== {16'h0, 16'hFFFF, 16'h0}) $display("FAIL clr_minmax: got %h/%h/%h want 0000/ffff/0000", delta_max, delta_min, delta_adj); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL clr_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if ({fifo_pending, pop_cnt[15:0]} !== {16'd1, 16'd1}) $display("FAIL clr_pending: got %0d/%0d want 1/1", fifo_pending, pop_cnt); else n_pass++;
    flush();
  endtask

  task automatic test_enable_drop();
    do_clear();
    pop_cnt = 0;
    lat_pkt_cnt = 16'd0;
    lat_offset = 16'd0;
    for (int i = 0; i < 5; i++) push(16'(i * 16), 16'(i * 16 + 8));
    lat_enable = 1'b1;
    repeat (2) cycle();
    lat_enable = 1'b0;
    n_checks++; if (busy !== 1'b1) $display("FAIL drop_busy_accum: got %b want 1", busy); else n_pass++;
    repeat (8) cycle();
    n_checks++; if ({delta_idx, busy} !== {32'd1, 1'b0}) $display("FAIL drop_idx: got %0d/%b want 1/0", delta_idx, busy); else n_pass++;
    n_checks++; if ({pop_cnt[15:0], fifo_pending} !== {16'd1, 16'd4}) $display("FAIL drop_pops: got %0d/%0d want 1/4", pop_cnt, fifo_pending); else n_pass++;
    lat_enable = 1'b1;
    cycle();
    lat_enable = 1'b0;
    repeat (8) cycle();
    n_checks++; if ({delta_idx, delta_acc} !== {32'd2, 32'h10}) $display("FAIL resume_idx_acc: got %0d/%h want 2/10", delta_idx, delta_acc); else n_pass++;
    n_checks++; if (pop_cnt !== 2) $display("FAIL resume_pops: got %0d want 2", pop_cnt); else n_pass++;
    flush();
  endtask

  task automatic test_saturation();
    do_clear();
    lat_pkt_cnt = 16'd0;
    lat_offset = 16'd0;
    force dut.u_stats.acc_q = 32'hFFFF_FF00;
    #1;
    release dut.u_stats.acc_q;
    #1;
    n_checks++; if (delta_acc !== 32'hFFFF_FF00) $display("FAIL sat_preload: got %h want ffffff00", delta_acc); else n_pass++;
    push(16'h0000, 16'hFFFF);
    lat_enable = 1'b1;
    repeat (5) cycle();
    n_checks++; if ({delta_acc, acc_ovf} !== {32'hFFFF_FFFF, 1'b1}) $display("FAIL sat_acc: got %h/%b want ffffffff/1", delta_acc, acc_ovf); else n_pass++;
    push(16'h0000, 16'h0001);
    repeat (5) cycle();
    n_checks++; if ({delta_acc, acc_ovf, delta_idx} !== {32'hFFFF_FFFF, 1'b1, 32'd2}) $display("FAIL sat_hold: got %h/%b/%0d want ffffffff/1/2", delta_acc, acc_ovf, delta_idx); else n_pass++;
    lat_enable = 1'b0;
    do_clear();
    n_checks++; if ({delta_acc, acc_ovf} !== {32'h0, 1'b0}) $display("FAIL sat_clear: got %h/%b want 0/0", delta_acc, acc_ovf); else n_pass++;
  endtask

  task automatic test_areset_mid();
    pop_cnt = 0;
    lat_pkt_cnt = 16'd0;
    push(16'h0010, 16'h0030);
    lat_enable = 1'b1;
    cycle();
    areset = 1'b1;
    #1;
    n_checks++; if (fifo_pop !== 1'b0) $display("FAIL arst_pop: got %b want 0", fifo_pop); else n_pass++;
    cycle();
    areset = 1'b0;
    lat_enable = 1'b0;
    n_checks++; if ({busy, fifo_pending, pop_cnt[15:0]} !== {1'b0, 16'd1, 16'd0}) $display("FAIL arst_state: got %b/%0d/%0d want 0/1/0", busy, fifo_pending, pop_cnt); else n_pass++;
    flush();
  endtask

  initial begin
    areset = 1'b1;
    lat_enable = 1'b0;
    lat_clear = 1'b0;
    lat_pkt_cnt = 16'd0;
    lat_offset = 16'd0;
    pop_cnt = 0;
    pop_due = 1'b0;
    upd_head();
    test_reset();
    test_empty();
    test_single();
    test_wrap();
    test_stats();
    test_clear_in_sample();
    test_enable_drop();
    test_saturation();
    test_areset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
